// File: rtl/sound_pkg.sv
// Shared types and default constants for the Breakout sound back end.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BRICK  = 2'd1,
        PADDLE = 2'd2
    } state_e;

    localparam int unsigned DEF_CLK_HZ      = 25_000_000;
    localparam int unsigned DEF_BRICK_HALF  = 14_204;     // ~880 Hz at 25 MHz
    localparam int unsigned DEF_PADDLE_HALF = 28_409;     // ~440 Hz at 25 MHz
    localparam int unsigned DEF_TONE_CYCLES = 2_500_000;  // 100 ms at 25 MHz
    localparam int unsigned DEF_CNT_W       = 24;

endpackage

// File: rtl/sound_player_tone_gen.sv
// Half-period counter and toggle flop producing a square wave of period 2*half.
// wave_next exposes the flop's next value so the caller can register it without extra latency.
module tone_gen
    import sound_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] half,
    output logic             wave,
    output logic             wave_next
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic             wave_q;

    always_comb begin
        half_cnt_d = half_cnt_q;
        wave_next  = wave_q;
        if (clear) begin
            half_cnt_d = '0;
            wave_next  = 1'b0;
        end else if (enable) begin
            if (half_cnt_q == half - CNT_ONE) begin
                half_cnt_d = '0;
                wave_next  = ~wave_q;
            end else begin
                half_cnt_d = half_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_cnt_q <= '0;
            wave_q     <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            wave_q     <= wave_next;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/sound_player.sv
// Breakout audio back end: edge-detects brick/paddle hit events and plays a
// fixed-length square-wave tone on a single speaker bit, brick tones taking priority.
module sound_player
    import sound_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned BRICK_HALF  = DEF_BRICK_HALF,
    parameter int unsigned PADDLE_HALF = DEF_PADDLE_HALF,
    parameter int unsigned TONE_CYCLES = DEF_TONE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic play_sound1,
    input  logic play_sound2,
    input  logic mute,
    output logic speaker,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TONE_LAST   = CNT_W'(TONE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BRICK_HALF_C  = CNT_W'(BRICK_HALF);
    localparam logic [CNT_W-1:0] PADDLE_HALF_C = CNT_W'(PADDLE_HALF);

    if (CLK_HZ == 0 || TONE_CYCLES == 0 || BRICK_HALF == 0 || PADDLE_HALF == 0 ||
        longint'(TONE_CYCLES) > (longint'(1) << CNT_W)) begin : g_param_check
        $error("sound_player: parameters out of range for CNT_W");
    end

    state_e           state_q, state_d;
    logic             prev1_q, prev2_q;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic             speaker_q, speaker_d;

    logic             rise1, rise2, accept, expire;
    logic             tone_clear;
    logic [CNT_W-1:0] tone_half;
    logic             wave, wave_next;

    // prev registers reset high so a line already asserted at reset release is not an event
    assign rise1  = play_sound1 & ~prev1_q;
    assign rise2  = play_sound2 & ~prev2_q;
    assign accept = rise1 | (rise2 & (state_q != BRICK));
    assign expire = (state_q != IDLE) && (dur_q == TONE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            prev1_q   <= 1'b1;
            prev2_q   <= 1'b1;
            dur_q     <= '0;
            speaker_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev1_q   <= play_sound1;
            prev2_q   <= play_sound2;
            dur_q     <= dur_d;
            speaker_q <= speaker_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise1)      state_d = BRICK;
                else if (rise2) state_d = PADDLE;
            end
            BRICK: begin
                if (rise1)       state_d = BRICK;
                else if (expire) state_d = IDLE;
            end
            PADDLE: begin
                if (rise1)       state_d = BRICK;
                else if (rise2)  state_d = PADDLE;
                else if (expire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // An accepted event restarts the tone from phase zero; IDLE keeps everything cleared.
    always_comb begin
        busy       = (state_q != IDLE);
        tone_clear = accept || (state_d == IDLE);
        tone_half  = (state_d == BRICK) ? BRICK_HALF_C : PADDLE_HALF_C;
        dur_d      = tone_clear ? '0 : dur_q + CNT_ONE;
        speaker_d  = wave_next & ~mute;
    end

    tone_gen #(
        .CNT_W (CNT_W)
    ) u_tone_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (tone_clear),
        .enable    (1'b1),
        .half      (tone_half),
        .wave      (wave),
        .wave_next (wave_next)
    );

    assign speaker = speaker_q;

endmodule

// File: tb/tb_sound_player.sv
// Scoreboard bench for sound_player: a tone-age reference model predicts busy/speaker per edge.
module tb_sound_player;

    localparam int BH   = 4;
    localparam int PH   = 8;
    localparam int TONE = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic play_sound1 = 1'b0;
    logic play_sound2 = 1'b0;
    logic mute = 1'b0;
    logic speaker;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [1:0] exp_q[$];

    sound_player #(
        .BRICK_HALF  (BH),
        .PADDLE_HALF (PH),
        .TONE_CYCLES (TONE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .play_sound1 (play_sound1),
        .play_sound2 (play_sound2),
        .mute        (mute),
        .speaker     (speaker),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got busy,speaker=%b expected %b", name, cyc, act, exp);
        end
    endtask

    // Reference model: which tone is playing and how many cycles since it started.
    int m_tone = 0;
    int m_age  = 0;
    logic m_prev1 = 1'b1;
    logic m_prev2 = 1'b1;

    initial begin
        logic r1, r2, e_busy, e_spk;
        int h;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                m_tone  = 0;
                m_age   = 0;
                m_prev1 = 1'b1;
                m_prev2 = 1'b1;
            end else begin
                r1 = play_sound1 && !m_prev1;
                r2 = play_sound2 && !m_prev2;
                m_prev1 = play_sound1;
                m_prev2 = play_sound2;
                if (r1) begin
                    m_tone = 1;
                    m_age  = 0;
                end else if (r2 && m_tone != 1) begin
                    m_tone = 2;
                    m_age  = 0;
                end else if (m_tone != 0) begin
                    m_age++;
                    if (m_age == TONE) m_tone = 0;
                end
            end
            h      = (m_tone == 1) ? BH : PH;
            e_busy = (m_tone != 0);
            e_spk  = (m_tone != 0) && (((m_age / h) % 2) == 1) && !mute;
            exp_q.push_back({e_busy, e_spk});
        end
    end

    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_out", {busy, speaker}, e);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s1, input logic s2);
        play_sound1 = s1;
        play_sound2 = s2;
        wait_cycles(1);
        play_sound1 = 1'b0;
        play_sound2 = 1'b0;
    endtask

    initial begin
        // reset with play_sound1 already high: no tone after release
        play_sound1 = 1'b1;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(20);
        play_sound1 = 1'b0;
        wait_cycles(5);

        // single brick tone
        pulse(1'b1, 1'b0);
        wait_cycles(80);

        // simultaneous rises -> brick, later paddle ignored
        pulse(1'b1, 1'b1);
        wait_cycles(20);
        pulse(1'b0, 1'b1);
        wait_cycles(60);

        // paddle preempted by brick, then brick retriggered
        pulse(1'b0, 1'b1);
        wait_cycles(19);
        pulse(1'b1, 1'b0);
        wait_cycles(19);
        pulse(1'b1, 1'b0);
        wait_cycles(80);

        // held level: one paddle tone only
        play_sound2 = 1'b1;
        wait_cycles(200);
        play_sound2 = 1'b0;
        wait_cycles(5);

        // mute mid-tone, then resume
        pulse(1'b1, 1'b0);
        wait_cycles(10);
        mute = 1'b1;
        wait_cycles(15);
        mute = 1'b0;
        wait_cycles(60);

        // asynchronous reset mid-tone
        pulse(1'b0, 1'b1);
        wait_cycles(20);
        #2 reset = 1'b0;
        #1 check("async_rst", {busy, speaker}, 2'b00);
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(5);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) play_sound1 = ~play_sound1;
            if ($urandom_range(0, 14) == 0) play_sound2 = ~play_sound2;
            if ($urandom_range(0, 29) == 0) mute = ~mute;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                #1 check("rand_rst", {busy, speaker}, 2'b00);
                wait_cycles(2);
                reset = 1'b1;
            end else begin
                wait_cycles(1);
            end
        end
        play_sound1 = 1'b0;
        play_sound2 = 1'b0;
        mute = 1'b0;
        wait_cycles(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
